rr_dec_arbiter: RTL and testbench

- Round-robin arbiter that shares one 3-to-8 one-hot select resource among 8 requesters.
- Sequences a requester index plus enable in the same form the team's 3-to-8 decoders consume, and drives the decoded one-hot grant word.
- Adds hold/release handshaking, a hold timeout, and a mandatory dead cycle between grants.
- Sits between 8 client blocks and a shared bus/peripheral select.

---
 rtl/rr_dec_arbiter_if.sv | 24 ++
 rtl/rr_dec_arbiter.sv | 105 ++++++++++
 tb/tb_rr_dec_arbiter.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/rr_dec_arbiter_if.sv
// Purpose: request/grant bundle between 8 clients and the round-robin decoder arbiter.
// Latency: n/a (wires only).
// Backpressure: level req held while wanted; done is a one-cycle release strobe.
// Ports: req[7:0], done (client -> arbiter); grant_en, grant_idx[2:0], grant[7:0], timeout (arbiter -> client).
interface rr_dec_arbiter_if;
  logic [7:0] req;
  logic       done;
  logic       grant_en;
  logic [2:0] grant_idx;
  logic [7:0] grant;
  logic       timeout;

  // Client side: raises requests, strobes done.
  modport master (
    output req, done,
    input  grant_en, grant_idx, grant, timeout
  );

  // Arbiter side.
  modport slave (
    input  req, done,
    output grant_en, grant_idx, grant, timeout
  );
endinterface

// File: rtl/rr_dec_arbiter.sv
// Purpose: round-robin arbiter sharing one 3-to-8 one-hot select among 8 requesters.
// Latency: req seen at an IDLE edge -> grant registered on that edge; >=1 dead cycle between grants.
// Backpressure: owner keeps grant until req drops, done strobes, or MAX_HOLD cycles elapse.
// Ports: clk, rst_n (async active-low); bus (slave modport): req, done in;
//        grant_en, grant_idx, grant (one-hot), timeout (one-cycle pulse) out.
module rr_dec_arbiter #(
  parameter int MAX_HOLD = 16,  // legal 2..2**HOLD_W
  parameter int HOLD_W   = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  rr_dec_arbiter_if.slave      bus
);

  typedef enum logic {IDLE, GRANT} state_t;

  localparam logic [HOLD_W-1:0] CNT_LAST = HOLD_W'(MAX_HOLD - 1);

  state_t              state_q;
  logic                grant_en_q;
  logic [2:0]          grant_idx_q;
  logic [7:0]          grant_q;
  logic                timeout_q;
  logic [2:0]          ptr_q;
  logic [HOLD_W-1:0]   cnt_q;

  // Next owner chosen in IDLE and the release causes evaluated in GRANT.
  logic                win_vld_d;
  logic [2:0]          win_idx_d;
  logic                rel_req_d;
  logic                rel_done_d;
  logic                rel_hold_d;
  logic                rel_any_d;

  // First set request bit scanning ptr, ptr+1, ... with 3-bit wrap.
  always_comb begin
    logic [2:0] cand;
    win_vld_d = 1'b0;
    win_idx_d = ptr_q;
    cand      = ptr_q;
    for (int k = 0; k < 8; k++) begin
      cand = ptr_q + 3'(k);
      if (!win_vld_d && bus.req[cand]) begin
        win_vld_d = 1'b1;
        win_idx_d = cand;
      end
    end
  end

  always_comb begin
    rel_req_d  = !bus.req[grant_idx_q];
    rel_done_d = bus.done;
    // cnt starts at 0 in the first granted cycle, so reaching MAX_HOLD-1
    // means the owner has held MAX_HOLD cycles including this one.
    rel_hold_d = (cnt_q == CNT_LAST);
    rel_any_d  = rel_req_d || rel_done_d || rel_hold_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      grant_en_q  <= 1'b0;
      grant_idx_q <= 3'd0;
      grant_q     <= 8'h00;
      timeout_q   <= 1'b0;
      ptr_q       <= 3'd0;
      cnt_q       <= '0;
    end else begin
      timeout_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (win_vld_d) begin
            state_q     <= GRANT;
            grant_en_q  <= 1'b1;
            grant_idx_q <= win_idx_d;
            // One-hot word is registered directly so it can never show a
            // transient multi-hot value while idx and enable change together.
            grant_q     <= 8'h01 << win_idx_d;
            cnt_q       <= '0;
          end
        end
        GRANT: begin
          if (rel_any_d) begin
            // Returning to IDLE forces the dead cycle before any new grant.
            state_q    <= IDLE;
            grant_en_q <= 1'b0;
            grant_q    <= 8'h00;
            ptr_q      <= grant_idx_q + 3'd1;
            // Timeout only when the hold limit is the sole cause.
            timeout_q  <= rel_hold_d && !rel_req_d && !rel_done_d;
          end else if (cnt_q != CNT_LAST) begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.grant_en  = grant_en_q;
  assign bus.grant_idx = grant_idx_q;
  assign bus.grant     = grant_q;
  assign bus.timeout   = timeout_q;

endmodule

// File: tb/tb_rr_dec_arbiter.sv
`timescale 1ns/1ps
module tb_rr_dec_arbiter;

  logic clk;
  logic rst_n;

  rr_dec_arbiter_if bif ();

  rr_dec_arbiter #(.MAX_HOLD(16), .HOLD_W(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] grant;
    logic [2:0] idx;
    logic       en;
    logic       to;
  } exp_t;

  exp_t       sb[$];
  int         total = 0;
  int         bad   = 0;
  logic [2:0] last_idx = 3'd0;

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Drive inputs for one cycle, queue what must appear after the next edge,
  // then pop and compare once the edge has passed.
  task automatic step(input logic [7:0] r, input logic d,
                      input logic [7:0] eg, input logic et);
    exp_t e;
    bif.req  = r;
    bif.done = d;
    for (int b = 0; b < 8; b++)
      if (eg[b]) last_idx = 3'(b);
    e.grant = eg;
    e.idx   = last_idx;
    e.en    = (eg != 8'h00);
    e.to    = et;
    sb.push_back(e);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    chk("grant",     bif.grant,            e.grant);
    chk("grant_en",  {7'd0, bif.grant_en}, {7'd0, e.en});
    chk("grant_idx", {5'd0, bif.grant_idx},{5'd0, e.idx});
    chk("timeout",   {7'd0, bif.timeout},  {7'd0, e.to});
  endtask

  task automatic do_reset();
    bif.req  = 8'h00;
    bif.done = 1'b0;
    rst_n    = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n    = 1'b1;
    last_idx = 3'd0;
    chk("rst_grant",    bif.grant,             8'h00);
    chk("rst_grant_en", {7'd0, bif.grant_en},  8'h00);
    chk("rst_idx",      {5'd0, bif.grant_idx}, 8'h00);
    chk("rst_timeout",  {7'd0, bif.timeout},   8'h00);
  endtask

  initial begin
    bif.req  = 8'h00;
    bif.done = 1'b0;
    rst_n    = 1'b0;

    // Idle: no requests, stray done strobes ignored.
    do_reset();
    for (int i = 0; i < 20; i++)
      step(8'h00, (i % 3 == 0), 8'h00, 1'b0);

    // Single requester, done on 3rd granted cycle, re-grant after dead cycle.
    do_reset();
    step(8'h01, 1'b0, 8'h01, 1'b0);
    step(8'h01, 1'b0, 8'h01, 1'b0);
    step(8'h01, 1'b0, 8'h01, 1'b0);
    step(8'h01, 1'b1, 8'h00, 1'b0);
    step(8'h01, 1'b0, 8'h01, 1'b0);
    step(8'h00, 1'b0, 8'h00, 1'b0);
    step(8'h00, 1'b0, 8'h00, 1'b0);

    // All requesting, each owner drops after 2 cycles: 0..7 then 0 again.
    do_reset();
    for (int i = 0; i < 9; i++) begin
      logic [7:0] oh;
      oh = 8'h01 << (i % 8);
      step(8'hFF, 1'b0, oh, 1'b0);
      step(8'hFF, 1'b0, oh, 1'b0);
      step(8'hFF & ~oh, 1'b0, 8'h00, 1'b0);
    end
    step(8'h00, 1'b0, 8'h00, 1'b0);

    // Hold limit: exactly 16 granted cycles, timeout pulse, re-grant.
    do_reset();
    for (int i = 0; i < 16; i++)
      step(8'h10, 1'b0, 8'h10, 1'b0);
    step(8'h10, 1'b0, 8'h00, 1'b1);
    step(8'h10, 1'b0, 8'h10, 1'b0);
    step(8'h00, 1'b0, 8'h00, 1'b0);

    // Wrap-around of the pointer.
    do_reset();
    step(8'h80, 1'b0, 8'h80, 1'b0);
    step(8'h00, 1'b0, 8'h00, 1'b0);
    step(8'h81, 1'b0, 8'h01, 1'b0);
    step(8'h00, 1'b0, 8'h00, 1'b0);
    step(8'h81, 1'b0, 8'h80, 1'b0);
    step(8'h00, 1'b0, 8'h00, 1'b0);

    // Done together with the hold limit: no timeout; then req swap at release.
    do_reset();
    for (int i = 0; i < 16; i++)
      step(8'h10, 1'b0, 8'h10, 1'b0);
    step(8'h10, 1'b1, 8'h00, 1'b0);
    step(8'h10, 1'b0, 8'h10, 1'b0);
    step(8'h08, 1'b0, 8'h00, 1'b0);
    step(8'h08, 1'b0, 8'h08, 1'b0);
    step(8'h00, 1'b0, 8'h00, 1'b0);

    // Async reset mid-grant, pointer restarts at 0.
    do_reset();
    step(8'hFF, 1'b0, 8'h01, 1'b0);
    step(8'hFE, 1'b0, 8'h00, 1'b0);
    step(8'hFF, 1'b0, 8'h02, 1'b0);
    step(8'hFF, 1'b0, 8'h02, 1'b0);
    rst_n = 1'b0;
    #1;
    chk("async_grant",    bif.grant,            8'h00);
    chk("async_grant_en", {7'd0, bif.grant_en}, 8'h00);
    #2;
    rst_n    = 1'b1;
    last_idx = 3'd0;
    step(8'hFF, 1'b0, 8'h01, 1'b0);
    step(8'h00, 1'b0, 8'h00, 1'b0);

    if (sb.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_left got=%0d exp=0", sb.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
